// File: rtl/signed_minmax_tracker.sv
// Streaming signed min/max/count tracker over framed valid/ready beats.
// Result is held in HOLD until the consumer takes it; no bypass.

module signed_minmax_slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    logic [N-1:0] diff;

    // Differing signs: the negative operand is smaller. Same sign: a-b cannot overflow.
    always_comb begin
        diff = a - b;
        if (a[N-1] != b[N-1]) lt = a[N-1];
        else                  lt = diff[N-1];
    end
endmodule

module signed_minmax_tracker #(
    parameter int N = 32,
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_min,
    output logic [N-1:0] out_max,
    output logic [C-1:0] out_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t       state;
    logic [N-1:0] min_q, max_q;
    logic [C-1:0] count_q;
    logic         ready_q, valid_q;
    logic         data_lt_min, max_lt_data;
    logic [C-1:0] count_inc;

    signed_minmax_slt #(.N(N)) u_slt_min (.a(in_data), .b(min_q), .lt(data_lt_min));
    signed_minmax_slt #(.N(N)) u_slt_max (.a(max_q), .b(in_data), .lt(max_lt_data));

    assign count_inc = (count_q == {C{1'b1}}) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    min_q   <= in_data;
                    max_q   <= in_data;
                    count_q <= {{(C-1){1'b0}}, 1'b1};
                    state   <= in_last ? HOLD : ACCUM;
                    ready_q <= ~in_last;
                    valid_q <= in_last;
                end
                ACCUM: if (in_valid) begin
                    if (data_lt_min) min_q <= in_data;
                    if (max_lt_data) max_q <= in_data;
                    count_q <= count_inc;
                    state   <= in_last ? HOLD : ACCUM;
                    ready_q <= ~in_last;
                    valid_q <= in_last;
                end
                HOLD: if (out_ready) begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;
endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Directed bench for signed_minmax_tracker; a C=2 instance shares the input stream.

module tb_signed_minmax_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_min, out_max;
    logic [15:0] out_count;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_min, s_out_max;
    logic [1:0]  s_out_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    signed_minmax_tracker #(.N(32), .C(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
        .out_count(out_count)
    );

    signed_minmax_tracker #(.N(32), .C(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_min(s_out_min), .out_max(s_out_max),
        .out_count(s_out_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int budget;
        budget = 20;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_wait in_ready=%0b required=1 after 20 cycles", in_ready);
        end
        tick();
    endtask

    task automatic run_frame(input logic [31:0] d[8], input int n);
        for (int i = 0; i < n; i++) send_beat(d[i], i == n - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] emin,
                                input logic [31:0] emax, input logic [15:0] ecnt);
        checks++;
        if (out_valid !== 1'b1 || out_min !== emin || out_max !== emax || out_count !== ecnt) begin
            failures++;
            $display("FAIL %s got v=%0b min=%h max=%h cnt=%0d required v=1 min=%h max=%h cnt=%0d",
                     name, out_valid, out_min, out_max, out_count, emin, emax, ecnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_min !== 32'h0 ||
            out_max !== 32'h0 || out_count !== 16'h0) begin
            failures++;
            $display("FAIL reset got v=%0b rdy=%0b min=%h max=%h cnt=%0d required v=0 rdy=1 zeros",
                     out_valid, in_ready, out_min, out_max, out_count);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] d[8];
        d = '{32'd5, -32'sd3, 32'd7, -32'sd8, 0, 0, 0, 0};
        out_ready = 1'b1;
        run_frame(d, 4);
        check_result("basic", 32'hFFFFFFF8, 32'd7, 16'd4);
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        logic [31:0] d[8];
        d = '{32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0};
        out_ready = 1'b1;
        run_frame(d, 1);
        check_result("single", 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd1);
        tick();
    endtask

    task automatic test_extremes();
        logic [31:0] d[8];
        d = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 0, 0, 0, 0, 0};
        out_ready = 1'b1;
        run_frame(d, 3);
        check_result("extremes", 32'h80000000, 32'h7FFFFFFF, 16'd3);
        tick();
        d = '{32'd4, 32'd4, 32'd4, 0, 0, 0, 0, 0};
        run_frame(d, 3);
        check_result("ties", 32'd4, 32'd4, 16'd3);
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] d[8];
        d = '{32'd10, 32'd20, 0, 0, 0, 0, 0, 0};
        out_ready = 1'b0;
        run_frame(d, 2);
        check_result("bp_result", 32'd10, 32'd20, 16'd2);
        in_valid = 1'b1;
        in_data  = 32'd99;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_min !== 32'd10 ||
                out_max !== 32'd20 || out_count !== 16'd2) begin
                failures++;
                $display("FAIL bp_hold[%0d] got rdy=%0b v=%0b min=%h max=%h cnt=%0d required rdy=0 v=1 10/20/2",
                         i, in_ready, out_valid, out_min, out_max, out_count);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got rdy=%0b v=%0b required rdy=1 v=0", in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_min !== 32'd99 || out_max !== 32'd99 || out_count !== 16'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_first_beat got min=%h max=%h cnt=%0d v=%0b required 99/99/1 v=0",
                     out_min, out_max, out_count, out_valid);
        end
        in_data = 32'd50;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_second_frame", 32'd50, 32'd99, 16'd2);
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 32'd1;
        tick();
        check_result("b2b_first", 32'd1, 32'd1, 16'd1);
        in_data = 32'd2;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_min !== 32'd1) begin
            failures++;
            $display("FAIL b2b_gap got v=%0b rdy=%0b min=%h required v=0 rdy=1 min=1",
                     out_valid, in_ready, out_min);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("b2b_second", 32'd2, 32'd2, 16'd1);
        tick();
    endtask

    task automatic test_saturation();
        logic [31:0] d[8];
        d = '{32'd3, -32'sd1, 32'd9, -32'sd4, 32'd2, 0, 0, 0};
        out_ready = 1'b1;
        run_frame(d, 5);
        check_result("sat_wide", 32'hFFFFFFFC, 32'd9, 16'd5);
        checks++;
        if (s_out_valid !== 1'b1 || s_out_count !== 2'd3 || s_out_min !== 32'hFFFFFFFC ||
            s_out_max !== 32'd9) begin
            failures++;
            $display("FAIL sat_c2 got v=%0b cnt=%0d min=%h max=%h required v=1 cnt=3 min=fffffffc max=9",
                     s_out_valid, s_out_count, s_out_min, s_out_max);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d[8];
        out_ready = 1'b1;
        send_beat(32'd7, 1'b0);
        send_beat(32'd3, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_min !== 32'h0 ||
            out_max !== 32'h0 || out_count !== 16'h0 || s_out_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid got v=%0b rdy=%0b min=%h max=%h cnt=%0d required v=0 rdy=1 zeros",
                     out_valid, in_ready, out_min, out_max, out_count);
        end
        tick();
        rst = 1'b1;
        tick();
        d = '{32'd1, 32'd2, 0, 0, 0, 0, 0, 0};
        run_frame(d, 2);
        check_result("after_reset", 32'd1, 32'd2, 16'd2);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_single();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
